// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the instruction-fetch port, the load/store port and
// the shared-memory port of mem_arbiter.
//   inst_*  : fetch requests in, addr_ok/data_ok/rdata back
//   data_*  : load/store requests in, addr_ok/data_ok/rdata back
//   mem_*   : single request channel out to memory, addr_ok/data_ok/rdata in
// Modports: slave  = the arbiter's view (takes CPU requests, drives memory)
//           master = the environment's view (CPU masters plus memory model)
interface mem_arbiter_if;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;

  logic        data_req;
  logic        data_wr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  logic        mem_req;
  logic        mem_wr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_addr_ok;
  logic        mem_data_ok;
  logic [31:0] mem_rdata;

  modport slave (
    input  inst_req, inst_addr,
    output inst_addr_ok, inst_data_ok, inst_rdata,
    input  data_req, data_wr, data_wstrb, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata,
    output mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata,
    input  mem_addr_ok, mem_data_ok, mem_rdata
  );

  modport master (
    output inst_req, inst_addr,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
    output data_req, data_wr, data_wstrb, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata,
    input  mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata,
    output mem_addr_ok, mem_data_ok, mem_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: merges an instruction-fetch master and a load/store master onto
// one in-order memory port. Requests pass through combinationally; an order
// FIFO of DEPTH one-bit entries remembers which master owns each outstanding
// transaction so in-order responses can be steered back.
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset
//   bus  - mem_arbiter_if.slave (inst_*, data_*, mem_* handshakes)
// Parameter DEPTH: max outstanding transactions (power of 2, >= 2).
module mem_arbiter #(
  parameter int unsigned DEPTH = 4
) (
  input logic           clk,
  input logic           rst,
  mem_arbiter_if.slave  bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

  typedef enum logic {
    SRC_INST = 1'b0,
    SRC_DATA = 1'b1
  } src_e;

  logic [DEPTH-1:0] order;
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic [PW:0]      count;
  logic [1:0]       starve_cnt;

  logic full;
  logic empty;
  src_e grant;
  logic accept;
  logic resp;
  src_e head;

  always_comb begin
    full  = (count == FULL_COUNT);
    empty = (count == '0);

    // Data wins unless inst is the only requester, or inst has already seen
    // three data accepts go ahead of it.
    grant = SRC_DATA;
    if (bus.inst_req && (!bus.data_req || starve_cnt == 2'd3))
      grant = SRC_INST;

    bus.mem_req = (bus.inst_req | bus.data_req) & ~full;
    accept      = bus.mem_req & bus.mem_addr_ok;

    if (grant == SRC_DATA) begin
      bus.mem_wr    = bus.data_wr;
      bus.mem_wstrb = bus.data_wstrb;
      bus.mem_addr  = bus.data_addr;
      bus.mem_wdata = bus.data_wdata;
    end else begin
      bus.mem_wr    = 1'b0;
      bus.mem_wstrb = '0;
      bus.mem_addr  = bus.inst_addr;
      bus.mem_wdata = '0;
    end

    bus.inst_addr_ok = accept & (grant == SRC_INST);
    bus.data_addr_ok = accept & (grant == SRC_DATA);

    // Responses with nothing outstanding (e.g. after reset) are dropped.
    head = src_e'(order[rptr]);
    resp = bus.mem_data_ok & ~empty;
    bus.inst_data_ok = resp & (head == SRC_INST);
    bus.data_data_ok = resp & (head == SRC_DATA);

    bus.inst_rdata = bus.mem_rdata;
    bus.data_rdata = bus.mem_rdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      starve_cnt <= '0;
    end else begin
      if (accept) begin
        order[wptr] <= grant;
        wptr        <= wptr + 1'b1;
      end
      if (resp)
        rptr <= rptr + 1'b1;

      case ({accept, resp})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      if (accept) begin
        if (grant == SRC_INST)
          starve_cnt <= '0;
        else if (bus.inst_req)
          starve_cnt <= starve_cnt + 2'd1;
      end
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: drives mem_arbiter through directed scenarios and a long
// random run, comparing every output each cycle with a reference model built
// from a queue of outstanding owners and an integer starvation counter.
module tb_mem_arbiter;
  localparam int unsigned DEPTH = 4;

  logic clk;
  logic rst;
  mem_arbiter_if bus ();

  mem_arbiter #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;

  // Reference model: owners of outstanding transactions (1 = data), oldest first.
  bit q[$];
  int starve;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Set request/handshake controls; payload fields get fresh random values.
  task automatic set_in(input bit ir, input bit dr, input bit maok, input bit mdok);
    bus.inst_req    = ir;
    bus.inst_addr   = $urandom;
    bus.data_req    = dr;
    bus.data_wr     = 1'($urandom);
    bus.data_wstrb  = 4'($urandom);
    bus.data_addr   = $urandom;
    bus.data_wdata  = $urandom;
    bus.mem_addr_ok = maok;
    bus.mem_data_ok = mdok;
    bus.mem_rdata   = $urandom;
  endtask

  // Called just after a negedge with inputs applied: checks outputs, then
  // advances the model across the next posedge.
  task automatic step();
    bit full, empty, gdata, exp_mreq, accept, resp, head;
    #2;
    full     = (q.size() == DEPTH);
    empty    = (q.size() == 0);
    exp_mreq = (bus.inst_req || bus.data_req) && !full;
    gdata    = !(bus.inst_req && (!bus.data_req || starve == 3));
    accept   = exp_mreq && bus.mem_addr_ok;
    resp     = bus.mem_data_ok && !empty;
    head     = empty ? 1'b0 : q[0];

    check("mem_req", 32'(bus.mem_req), 32'(exp_mreq));
    check("mem_addr", bus.mem_addr, gdata ? bus.data_addr : bus.inst_addr);
    check("mem_wr", 32'(bus.mem_wr), gdata ? 32'(bus.data_wr) : 32'd0);
    check("mem_wstrb", 32'(bus.mem_wstrb), gdata ? 32'(bus.data_wstrb) : 32'd0);
    check("mem_wdata", bus.mem_wdata, gdata ? bus.data_wdata : 32'd0);
    check("inst_addr_ok", 32'(bus.inst_addr_ok), 32'(accept && !gdata));
    check("data_addr_ok", 32'(bus.data_addr_ok), 32'(accept && gdata));
    check("inst_data_ok", 32'(bus.inst_data_ok), 32'(resp && !head));
    check("data_data_ok", 32'(bus.data_data_ok), 32'(resp && head));
    check("inst_rdata", bus.inst_rdata, bus.mem_rdata);
    check("data_rdata", bus.data_rdata, bus.mem_rdata);

    @(posedge clk);
    if (rst) begin
      q.delete();
      starve = 0;
    end else begin
      if (resp) void'(q.pop_front());
      if (accept) begin
        q.push_back(gdata);
        if (!gdata) starve = 0;
        else if (bus.inst_req) starve = (starve + 1) % 4;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    starve = 0;
    rst = 1'b1;
    set_in(0, 0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    q.delete();

    // Reset state held for one checked cycle.
    set_in(1, 1, 1, 1);
    step();
    rst = 1'b0;

    // Single fetch and its response.
    set_in(1, 0, 1, 0);
    bus.inst_addr = 32'h1C00_0000;
    step();
    set_in(0, 0, 0, 1);
    bus.mem_rdata = 32'h0280_0C0C;
    #2;
    check("dir_inst_data_ok", 32'(bus.inst_data_ok), 32'd1);
    check("dir_inst_rdata", bus.inst_rdata, 32'h0280_0C0C);
    step();

    // Starvation: three data grants then inst; queue becomes full.
    for (int i = 0; i < 4; i++) begin
      set_in(1, 1, 1, 0);
      #2;
      check("dir_starve_grant", 32'(bus.inst_addr_ok), (i == 3) ? 32'd1 : 32'd0);
      step();
    end
    // Full: nothing accepted, then a response frees a slot.
    set_in(1, 1, 1, 0);
    #2;
    check("dir_full_mem_req", 32'(bus.mem_req), 32'd0);
    step();
    set_in(1, 0, 0, 1);
    step();
    set_in(1, 0, 1, 0);
    #2;
    check("dir_unfull_mem_req", 32'(bus.mem_req), 32'd1);
    step();
    // Drain, exercising simultaneous accept+response across the pointer wrap.
    for (int i = 0; i < 6; i++) begin
      set_in(i < 3, 1, 1, 1);
      step();
    end
    while (q.size() != 0) begin
      set_in(0, 0, 0, 1);
      step();
    end

    // Reset with transactions outstanding; later response is ignored.
    set_in(1, 1, 1, 0);
    step();
    step();
    rst = 1'b1;
    set_in(0, 0, 0, 0);
    step();
    rst = 1'b0;
    set_in(0, 0, 0, 1);
    #2;
    check("dir_post_rst_data_ok", 32'({bus.inst_data_ok, bus.data_data_ok}), 32'd0);
    step();

    // Random traffic with occasional reset.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      set_in($urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0,
             $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
      step();
    end
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
